// File: rtl/fpu_align_unit.sv
// fpu_align_unit: binary16 pre-add alignment stage; define FPU_ALIGN_FAST_SHIFT_EN for a single-cycle barrel shift
module fpu_align_unit #(
   parameter int MAX_SHIFT = 12,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] man_l,
   output logic [11:0] man_s,
   output logic [4:0]  exp_base,
   output logic        sign_l,
   output logic        sign_s,
   output logic        swap,
   output logic        sticky,
   output logic        special
);
   typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;
   state_t state;
   logic b_gt;
   logic [15:0] op_l, op_s;
   logic [4:0] eff_l, eff_s, diff;
   logic [11:0] sig_l, sig_s;
   logic [CNT_W-1:0] n;
`ifndef FPU_ALIGN_FAST_SHIFT_EN
   logic [CNT_W-1:0] cnt;
`endif
   always_comb begin
      b_gt = op_b[14:0] > op_a[14:0];
      op_l = b_gt ? op_b : op_a;
      op_s = b_gt ? op_a : op_b;
      eff_l = (op_l[14:10] == 5'd0) ? 5'd1 : op_l[14:10];
      eff_s = (op_s[14:10] == 5'd0) ? 5'd1 : op_s[14:10];
      sig_l = {1'b0, |op_l[14:10], op_l[9:0]};
      sig_s = {1'b0, |op_s[14:10], op_s[9:0]};
      diff = eff_l - eff_s;
      n = (diff > 5'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : CNT_W'(diff);
   end
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         man_l <= '0;
         man_s <= '0;
         exp_base <= '0;
         sign_l <= 1'b0;
         sign_s <= 1'b0;
         swap <= 1'b0;
         sticky <= 1'b0;
         special <= 1'b0;
`ifndef FPU_ALIGN_FAST_SHIFT_EN
         cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               man_l <= sig_l;
               exp_base <= eff_l;
               sign_l <= op_l[15];
               sign_s <= op_s[15];
               swap <= b_gt;
               special <= (&op_a[14:10]) | (&op_b[14:10]);
`ifdef FPU_ALIGN_FAST_SHIFT_EN
               man_s <= sig_s >> n;
               sticky <= |(sig_s & ~(12'hfff << n));
               state <= DONE;
`else
               man_s <= sig_s;
               sticky <= 1'b0;
               cnt <= n;
               state <= ALIGN;
`endif
            end
`ifdef FPU_ALIGN_FAST_SHIFT_EN
            ALIGN: state <= DONE;
`else
            ALIGN: if (cnt != '0) begin
               man_s <= man_s >> 1;
               sticky <= sticky | man_s[0];
               cnt <= cnt - 1'b1;
            end else begin
               state <= DONE;
            end
`endif
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_align_unit.sv
// tb_fpu_align_unit: directed vectors checked against an arithmetic model of the alignment stage
module tb_fpu_align_unit;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [15:0] op_a = 0, op_b = 0;
   logic in_ready, out_valid, sign_l, sign_s, swap, sticky, special;
   logic [11:0] man_l, man_s;
   logic [4:0] exp_base;
   int errors = 0, checks = 0;
   typedef struct {int man_l, man_s, exp_base, sign_l, sign_s, swap, sticky, special, lat;} exp_t;
   exp_t cur;
   bit cur_ok = 0;
   int g_ml, g_ms, g_eb, g_sw, g_st, g_sp;

   fpu_align_unit dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .man_l(man_l), .man_s(man_s), .exp_base(exp_base), .sign_l(sign_l), .sign_s(sign_s),
      .swap(swap), .sticky(sticky), .special(special));

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(logic [15:0] a, logic [15:0] b);
      exp_t r;
      int ea = int'(a[14:10]), eb = int'(b[14:10]);
      int ma = int'(a[14:0]), mb = int'(b[14:0]);
      int el, es, sl, ss, n, div;
      bit sw = mb > ma;
      el = sw ? eb : ea;
      es = sw ? ea : eb;
      sl = (el != 0 ? 1024 : 0) + (sw ? int'(b[9:0]) : int'(a[9:0]));
      ss = (es != 0 ? 1024 : 0) + (sw ? int'(a[9:0]) : int'(b[9:0]));
      if (el == 0) el = 1;
      if (es == 0) es = 1;
      n = el - es;
      if (n > 12) n = 12;
      div = 1 << n;
      r.man_l = sl;
      r.man_s = ss / div;
      r.sticky = (ss % div) != 0;
      r.exp_base = el;
      r.sign_l = sw ? int'(b[15]) : int'(a[15]);
      r.sign_s = sw ? int'(a[15]) : int'(b[15]);
      r.swap = sw;
      r.special = (ea == 31 || eb == 31);
`ifdef FPU_ALIGN_FAST_SHIFT_EN
      r.lat = 1;
`else
      r.lat = n + 1;
`endif
      return r;
   endfunction

   // every cycle a result is presented it must match the model and block new input
   always @(negedge clk) begin
      if (!rst && cur_ok && out_valid) begin
         chk("man_l", int'(man_l), cur.man_l);
         chk("man_s", int'(man_s), cur.man_s);
         chk("exp_base", int'(exp_base), cur.exp_base);
         chk("sign_l", int'(sign_l), cur.sign_l);
         chk("sign_s", int'(sign_s), cur.sign_s);
         chk("swap", int'(swap), cur.swap);
         chk("sticky", int'(sticky), cur.sticky);
         chk("special", int'(special), cur.special);
         chk("in_ready_busy", int'(in_ready), 0);
      end
   end

   task automatic run_op(logic [15:0] a, logic [15:0] b, int hold);
      int k;
      cur = model(a, b);
      cur_ok = 1;
      chk("in_ready_idle", int'(in_ready), 1);
      op_a = a;
      op_b = b;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      chk("latency", k, cur.lat);
      g_ml = int'(man_l); g_ms = int'(man_s); g_eb = int'(exp_base);
      g_sw = int'(swap); g_st = int'(sticky); g_sp = int'(special);
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         op_a = 16'($urandom);
         op_b = 16'($urandom);
         @(posedge clk);
         #1 chk("held_valid", int'(out_valid), 1);
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      chk("release_valid", int'(out_valid), 0);
      chk("release_ready", int'(in_ready), 1);
   endtask

   initial begin
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_man_l", int'(man_l), 0);
      rst = 0;
      @(posedge clk);
      #1;
      run_op(16'h3C00, 16'h3800, 0);
      chk("lit1_man_l", g_ml, 'h400); chk("lit1_man_s", g_ms, 'h200);
      chk("lit1_exp", g_eb, 15); chk("lit1_swap", g_sw, 0); chk("lit1_sticky", g_st, 0);
      run_op(16'h3800, 16'h3C00, 0);
      chk("lit2_man_s", g_ms, 'h200); chk("lit2_swap", g_sw, 1);
      run_op(16'h7800, 16'h3C01, 5);
      chk("lit3_man_l", g_ml, 'h400); chk("lit3_man_s", g_ms, 0);
      chk("lit3_exp", g_eb, 30); chk("lit3_sticky", g_st, 1);
      run_op(16'h0400, 16'h0200, 0);
      chk("lit4_man_s", g_ms, 'h200); chk("lit4_exp", g_eb, 1);
      run_op(16'h0000, 16'h0000, 0);
      chk("lit5_exp", g_eb, 1); chk("lit5_man_l", g_ml, 0);
      run_op(16'h4000, 16'h3C01, 1);
      chk("lit6_man_s", g_ms, 'h200); chk("lit6_sticky", g_st, 1);
      run_op(16'h7C00, 16'h3C00, 0);
      chk("lit7_special", g_sp, 1); chk("lit7_exp", g_eb, 31);
      run_op(16'h3C00, 16'hBC00, 0);
      run_op(16'h8001, 16'h03FF, 2);
      // asynchronous reset partway through a long alignment
      cur = model(16'h7800, 16'h3C01);
      op_a = 16'h7800;
      op_b = 16'h3C01;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_man_s", int'(man_s), 0);
      chk("arst_exp", int'(exp_base), 0);
      chk("arst_sticky", int'(sticky), 0);
      @(posedge clk);
      #1 rst = 0;
      @(posedge clk);
      #1;
      run_op(16'h3C00, 16'h3800, 0);
      chk("post_rst_man_s", g_ms, 'h200);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
